// File: rtl/pcf8563_rtc_seq_pkg.sv
// pcf8563_rtc_seq_pkg: PCF8563 register map, field masks and sequencer state encodings
package pcf8563_rtc_seq_pkg;
  localparam logic [7:0] REG_CTRL1 = 8'h00;
  localparam logic [7:0] REG_CTRL2 = 8'h01;
  localparam logic [7:0] REG_SEC = 8'h02;
  localparam logic [7:0] REG_MIN = 8'h03;
  localparam logic [7:0] REG_HOUR = 8'h04;
  localparam logic [7:0] REG_DAY = 8'h05;
  localparam logic [7:0] REG_WDAY = 8'h06;
  localparam logic [7:0] REG_MONTH = 8'h07;
  localparam logic [7:0] REG_YEAR = 8'h08;
  localparam logic [7:0] DEF_DEV_ADDR = 8'hA2;
  localparam int VL_BIT = 7;
  localparam logic [7:0][7:0] FIELD_MASKS = {8'h00, 8'hFF, 8'h1F, 8'h07, 8'h3F, 8'h3F, 8'h7F, 8'h7F};
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_ERR} state_t;
  function automatic logic [7:0] field_mask(input logic [2:0] i);
    return FIELD_MASKS[i];
  endfunction
endpackage

// File: rtl/pcf8563_rtc_seq_poll_timer.sv
// pcf8563_rtc_seq_poll_timer: idle-time poll counter and pending-read flag
module pcf8563_rtc_seq_poll_timer #(
  parameter int POLL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic set_pend,
  input  logic clr_pend,
  output logic pend
);
  logic [31:0] cnt;
  logic wrap;
  assign wrap = run && cnt == 32'(POLL_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pend <= 1'b0;
    end else begin
      if (run) cnt <= wrap ? '0 : cnt + 32'd1;
      pend <= (set_pend || (wrap && !clr_pend)) ? 1'b1 : clr_pend ? 1'b0 : pend;
    end
  end
endmodule

// File: rtl/pcf8563_rtc_seq.sv
// pcf8563_rtc_seq: burst read/write sequencer for PCF8563 time registers over a byte-level I2C controller
module pcf8563_rtc_seq
  import pcf8563_rtc_seq_pkg::*;
#(
  parameter int POLL_CYCLES = 50_000_000,
  parameter logic [7:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_req,
  input  logic [55:0] set_time,
  input  logic        rd_now,
  output logic [55:0] time_out,
  output logic        time_vld,
  output logic        vl_flag,
  output logic        busy,
  output logic        err,
  output logic        wr_req,
  output logic        rd_req,
  output logic [15:0] addr,
  output logic        addr_mode,
  output logic [7:0]  wr_data,
  output logic [7:0]  device_id,
  input  logic [7:0]  rd_data,
  input  logic        rw_done,
  input  logic        ack
);
  state_t state;
  logic [2:0] idx, nidx;
  logic is_wr, vl, poll_pend, rd_accept;
  logic [7:0] reg_addr;
  logic [55:0] snap, shadow;
  logic [31:0] tcnt;
  assign nidx = idx + 3'd1;
  assign rd_accept = state == S_IDLE && !set_req && poll_pend;
  assign busy = state != S_IDLE;
  assign addr = {8'h00, reg_addr};
  assign addr_mode = 1'b0;
  assign device_id = DEV_ADDR;
  // a rd_now landing on the cycle a read is accepted merges into that read
  pcf8563_rtc_seq_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(state == S_IDLE),
    .set_pend((rd_now && !rd_accept) || (state == S_DONE && is_wr)),
    .clr_pend(rd_accept),
    .pend(poll_pend)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      is_wr <= 1'b0;
      vl <= 1'b0;
      snap <= '0;
      shadow <= '0;
      tcnt <= '0;
      reg_addr <= '0;
      time_out <= '0;
      time_vld <= 1'b0;
      vl_flag <= 1'b0;
      err <= 1'b0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      wr_data <= '0;
    end else begin
      time_vld <= 1'b0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      case (state)
        S_IDLE: if (set_req || poll_pend) begin
          is_wr <= set_req;
          idx <= '0;
          if (set_req) snap <= set_time;
          reg_addr <= REG_SEC;
          wr_data <= set_req ? set_time[7:0] : 8'h00;
          wr_req <= set_req;
          rd_req <= !set_req;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          tcnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (rw_done) begin
          if (ack) state <= S_ERR;
          else begin
            if (!is_wr) shadow[{idx, 3'b000} +: 8] <= rd_data & field_mask(idx);
            if (!is_wr && idx == 3'd0) vl <= rd_data[VL_BIT];
            state <= S_NEXT;
          end
        end else if (tcnt == 32'(TIMEOUT_CYCLES - 1)) state <= S_ERR;
        else tcnt <= tcnt + 32'd1;
        S_NEXT: if (idx == 3'd6) state <= S_DONE;
        else begin
          idx <= nidx;
          reg_addr <= reg_addr + 8'd1;
          wr_data <= is_wr ? snap[{nidx, 3'b000} +: 8] : 8'h00;
          wr_req <= is_wr;
          rd_req <= !is_wr;
          state <= S_ISSUE;
        end
        S_DONE: begin
          err <= 1'b0;
          if (!is_wr) begin
            time_out <= shadow;
            vl_flag <= vl;
            time_vld <= 1'b1;
          end
          state <= S_IDLE;
        end
        S_ERR: begin
          err <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcf8563_rtc_seq.sv
// tb_pcf8563_rtc_seq: I2C controller model with RTC register file and scoreboards for the sequencer
module tb_pcf8563_rtc_seq;
  logic clk = 0, rst = 1, set_req = 0, rd_now = 0, rw_done = 0, ack = 0;
  logic [55:0] set_time = '0;
  logic [7:0] rd_data = '0;
  logic [55:0] time_out;
  logic time_vld, vl_flag, busy, err, wr_req, rd_req, addr_mode;
  logic [15:0] addr;
  logic [7:0] wr_data, device_id;

  always #5 clk = ~clk;

  pcf8563_rtc_seq #(.POLL_CYCLES(100), .DEV_ADDR(8'hA2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .set_time(set_time), .rd_now(rd_now),
    .time_out(time_out), .time_vld(time_vld), .vl_flag(vl_flag), .busy(busy), .err(err),
    .wr_req(wr_req), .rd_req(rd_req), .addr(addr), .addr_mode(addr_mode), .wr_data(wr_data),
    .device_id(device_id), .rd_data(rd_data), .rw_done(rw_done), .ack(ack)
  );

  int checks = 0, errors = 0, n_vld = 0, n_wr = 0, n_rd = 0;
  logic [7:0] rtc_regs [7] = '{8'h85, 8'h59, 8'h23, 8'h31, 8'h06, 8'h12, 8'h99};
  logic [7:0] masks [7] = '{8'h7F, 8'h7F, 8'h3F, 8'h3F, 8'h07, 8'h1F, 8'hFF};
  bit mute = 0;
  int nack_at = -1;
  logic [56:0] exp_vld [$];
  logic [7:0] exp_wr [$];
  logic [55:0] acc = '0;
  logic acc_vl = 0;
  logic [15:0] exp_a = 16'h0002;
  bit m_w;
  int m_i;
  logic [7:0] m_d;
  logic [56:0] ev;
  logic [7:0] eb;

  // controller model: answers each request 20 cycles later, writes update the RTC registers
  initial forever begin
    @(negedge clk);
    if (!rst && (rd_req || wr_req)) begin
      m_w = wr_req;
      m_i = int'(addr[3:0]) - 2;
      m_d = wr_data;
      repeat (19) @(negedge clk);
      if (!mute && m_i >= 0 && m_i < 7) begin
        ack = !m_w && m_i == nack_at;
        rd_data = m_w ? 8'h00 : rtc_regs[m_i];
        if (m_w) rtc_regs[m_i] = m_d;
        else if (!ack) begin
          acc[8*m_i +: 8] = rtc_regs[m_i] & masks[m_i];
          if (m_i == 0) acc_vl = rtc_regs[0][7];
          if (m_i == 6) exp_vld.push_back({acc_vl, acc});
        end
        rw_done = 1;
        @(negedge clk);
        rw_done = 0;
        ack = 0;
      end
    end
  end

  // request monitor: address sequence, write data scoreboard, mutual exclusion
  always @(negedge clk) begin
    if (wr_req && rd_req) begin
      errors++;
      $display("FAIL req_excl wr_req and rd_req both high");
    end
    if (rst || !busy) exp_a = 16'h0002;
    else if (wr_req || rd_req) begin
      checks++;
      if (addr !== exp_a) begin
        errors++;
        $display("FAIL addr got %h exp %h", addr, exp_a);
      end
      exp_a = exp_a + 16'd1;
      if (wr_req) begin
        n_wr++;
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_data unexpected write got %h", wr_data);
        end else begin
          eb = exp_wr.pop_front();
          if (wr_data !== eb) begin
            errors++;
            $display("FAIL wr_data got %h exp %h", wr_data, eb);
          end
        end
      end else n_rd++;
    end
  end

  // snapshot monitor
  always @(negedge clk) if (!rst && time_vld) begin
    n_vld++;
    checks++;
    if (exp_vld.size() == 0) begin
      errors++;
      $display("FAIL snapshot unexpected time_vld time_out %h", time_out);
    end else begin
      ev = exp_vld.pop_front();
      if ({vl_flag, time_out} !== ev) begin
        errors++;
        $display("FAIL snapshot got %h exp %h", {vl_flag, time_out}, ev);
      end
    end
  end

  task automatic wait_busy(input logic lvl, input int budget, output int cyc);
    cyc = -1;
    for (int k = 0; k < budget && cyc < 0; k++) begin
      @(negedge clk);
      if (busy === lvl) cyc = k;
    end
  endtask

  task automatic wait_vld(input int budget, output int cyc);
    cyc = -1;
    for (int k = 0; k < budget && cyc < 0; k++) begin
      @(negedge clk);
      if (time_vld === 1'b1) cyc = k;
    end
  endtask

  task automatic pulse_set(input logic [55:0] t);
    set_time = t;
    for (int b = 0; b < 7; b++) exp_wr.push_back(t[8*b +: 8]);
    set_req = 1;
    @(negedge clk);
    set_req = 0;
  endtask

  task automatic pulse_rd_now();
    rd_now = 1;
    @(negedge clk);
    rd_now = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({time_out, time_vld, vl_flag, busy, err, wr_req, rd_req, addr, addr_mode, wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got time_out %h vld %b vl %b busy %b err %b wr %b rd %b addr %h wd %h",
               time_out, time_vld, vl_flag, busy, err, wr_req, rd_req, addr, wr_data);
    end
    checks++;
    if (device_id !== 8'hA2) begin
      errors++;
      $display("FAIL reset_device_id got %h exp a2", device_id);
    end
  endtask

  task automatic test_first_read();
    int cyc = -1;
    rst = 0;
    for (int k = 0; k < 200 && cyc < 0; k++) begin
      @(negedge clk);
      if (rd_req === 1'b1) cyc = k;
    end
    checks++;
    if (cyc < 99 || cyc > 102) begin
      errors++;
      $display("FAIL first_poll_time got %0d exp ~100", cyc);
    end
    wait_vld(300, cyc);
    checks++;
    if (cyc < 0 || time_out !== 56'h99_12_06_31_23_59_05 || vl_flag !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL first_read got %h vl %b err %b exp 99120631235905 vl 1 err 0", time_out, vl_flag, err);
    end
    @(negedge clk);
    checks++;
    if (time_vld !== 1'b0) begin
      errors++;
      $display("FAIL vld_pulse_width got %b exp 0", time_vld);
    end
  endtask

  task automatic test_set_time();
    int cyc, w0;
    wait_busy(0, 400, cyc);
    w0 = n_wr;
    pulse_set(56'h24_01_01_15_08_30_00);
    checks++;
    if (wr_req !== 1'b1) begin
      errors++;
      $display("FAIL set_start wr_req got %b exp 1", wr_req);
    end
    wait_busy(0, 300, cyc);
    wait_busy(1, 5, cyc);
    checks++;
    if (cyc < 0 || rd_req !== 1'b1) begin
      errors++;
      $display("FAIL readback_start got cyc %0d rd_req %b exp read within 5", cyc, rd_req);
    end
    checks++;
    if (n_wr - w0 != 7) begin
      errors++;
      $display("FAIL write_count got %0d exp 7", n_wr - w0);
    end
    wait_vld(300, cyc);
    checks++;
    if (cyc < 0 || time_out !== 56'h24_01_01_15_08_30_00 || vl_flag !== 1'b0) begin
      errors++;
      $display("FAIL readback got %h vl %b exp 24010115083000 vl 0", time_out, vl_flag);
    end
  endtask

  task automatic test_nack();
    int cyc, v0;
    wait_busy(0, 400, cyc);
    v0 = n_vld;
    nack_at = 2;
    pulse_rd_now();
    wait_busy(1, 10, cyc);
    wait_busy(0, 300, cyc);
    nack_at = -1;
    checks++;
    if (cyc < 0 || err !== 1'b1 || n_vld != v0 || time_out !== 56'h24_01_01_15_08_30_00) begin
      errors++;
      $display("FAIL nack got cyc %0d err %b vld %0d time_out %h exp err 1 no vld unchanged", cyc, err, n_vld - v0, time_out);
    end
    wait_vld(400, cyc);
    checks++;
    if (cyc < 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL nack_recover got cyc %0d err %b exp err 0", cyc, err);
    end
  endtask

  task automatic test_timeout();
    int cyc = -1;
    wait_busy(0, 400, cyc);
    mute = 1;
    pulse_rd_now();
    cyc = -1;
    for (int k = 0; k < 10 && cyc < 0; k++) begin
      if (rd_req === 1'b1) cyc = k;
      else @(negedge clk);
    end
    wait_busy(0, 200, cyc);
    checks++;
    if (cyc < 49 || cyc > 53 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout got %0d cycles err %b exp ~51 err 1", cyc, err);
    end
    repeat (20) @(negedge clk);
    mute = 0;
    wait_vld(400, cyc);
    checks++;
    if (cyc < 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover got cyc %0d err %b exp err 0", cyc, err);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = -1, v0, quiet = 1;
    for (int k = 0; k < 1000 && cyc < 0; k++) begin
      @(negedge clk);
      if (busy === 1'b0 && dut.u_timer.cnt == 32'd99) cyc = k;
    end
    v0 = n_vld;
    pulse_set(56'h25_12_03_31_23_59_58);
    checks++;
    if (cyc < 0 || wr_req !== 1'b1) begin
      errors++;
      $display("FAIL collision_write_first got cyc %0d wr_req %b exp 1", cyc, wr_req);
    end
    wait_busy(0, 300, cyc);
    wait_busy(1, 5, cyc);
    checks++;
    if (cyc < 0 || rd_req !== 1'b1) begin
      errors++;
      $display("FAIL collision_read_next got cyc %0d rd_req %b", cyc, rd_req);
    end
    repeat (40) @(negedge clk);
    pulse_rd_now();
    wait_busy(0, 300, cyc);
    wait_busy(1, 5, cyc);
    checks++;
    if (cyc < 0 || rd_req !== 1'b1) begin
      errors++;
      $display("FAIL rd_now_extra got cyc %0d rd_req %b", cyc, rd_req);
    end
    wait_busy(0, 300, cyc);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (quiet == 0 || n_vld - v0 != 2) begin
      errors++;
      $display("FAIL rd_now_once got quiet %0d reads %0d exp quiet 1 reads 2", quiet, n_vld - v0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = -1;
    for (int k = 0; k < 400 && cyc < 0; k++) begin
      @(negedge clk);
      if (rd_req === 1'b1 && addr === 16'h0005) cyc = k;
    end
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (cyc < 0 || {time_out, time_vld, vl_flag, busy, err, wr_req, rd_req, addr, wr_data} !== '0 || device_id !== 8'hA2) begin
      errors++;
      $display("FAIL reset_mid got cyc %0d time_out %h busy %b err %b addr %h dev %h", cyc, time_out, busy, err, addr, device_id);
    end
    rst = 0;
    wait_vld(400, cyc);
    checks++;
    if (cyc < 0 || time_out !== 56'h25_12_03_31_23_59_58 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover got cyc %0d time_out %h err %b exp 25120331235958", cyc, time_out, err);
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_set_time();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_vld.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got snapshots %0d writes %0d exp 0 0", exp_vld.size(), exp_wr.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
